// File: rtl/flags_stack.sv
// ----------------------------------------------------------------------------
// flags_stack
//
// Live CPU flags word (for WIDTH=4: [3]=CF, [2]=OF, [1]=NF, [0]=ZF) with
// per-bit masked writes, plus a LIFO save/restore stack of flag words used on
// interrupt entry/return and nested calls.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-low reset
//   FLAGS      in   new flag values from the ALU
//   FWE        in   flag write enable
//   MASK       in   per-bit write mask (1 = bit updated when FWE=1)
//   PUSH       in   save live word onto the stack
//   POP        in   restore live word from top of stack
//   CLR_ERR    in   clear sticky error bits
//   FLAGS_OUT  out  live flags word (registered)
//   SP         out  occupied stack entries, 0..DEPTH
//   FULL       out  SP == DEPTH
//   EMPTY      out  SP == 0
//   OVF_ERR    out  sticky: PUSH attempted while full
//   UNF_ERR    out  sticky: POP attempted while empty
// ----------------------------------------------------------------------------
module flags_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] FLAGS,
  input  logic             FWE,
  input  logic [WIDTH-1:0] MASK,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] FLAGS_OUT,
  output logic [SPW-1:0]   SP,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVF_ERR,
  output logic             UNF_ERR
);

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic             full, empty;
  logic             do_push, do_pop;
  logic [SPW-1:0]   top_idx;
  logic [WIDTH-1:0] top_word;

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  // PUSH and POP together cancel: no stack operation and no error.
  assign do_push = PUSH && !POP && !full;
  assign do_pop  = POP && !PUSH && !empty;
  assign top_idx = sp_q - SPW'(1);

  // Top-of-stack read done by comparison so the SP width need not match the
  // array index width (DEPTH is not required to be a power of two).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    top_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (SPW'(i) == top_idx) top_word = stack_q[i];
    end
  end

  always_comb begin
    flags_d = flags_q;
    sp_d    = sp_q;
    stack_d = stack_q;

    // A pop restores the saved word and overrides any same-cycle write.
    if (do_pop) begin
      flags_d = top_word;
      sp_d    = sp_q - SPW'(1);
    end else if (FWE) begin
      flags_d = (flags_q & ~MASK) | (FLAGS & MASK);
    end

    // The pushed value is the pre-edge live word, not the one being written.
    if (do_push) begin
      sp_d = sp_q + SPW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (SPW'(i) == sp_q) stack_d[i] = flags_q;
      end
    end

    // Set wins over clear so an error coinciding with CLR_ERR is not lost.
    ovf_d = (ovf_q && !CLR_ERR) || (PUSH && !POP && full);
    unf_d = (unf_q && !CLR_ERR) || (POP && !PUSH && empty);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      // NOTE: the stack storage is reset too, so no unreset entry can ever be
      // restored onto FLAGS_OUT; this costs reset fanout but removes X sources.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      flags_q <= flags_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign FLAGS_OUT = flags_q;
  assign SP        = sp_q;
  assign FULL      = full;
  assign EMPTY     = empty;
  assign OVF_ERR   = ovf_q;
  assign UNF_ERR   = unf_q;

endmodule

// File: tb/tb_flags_stack.sv
// ----------------------------------------------------------------------------
// tb_flags_stack
//
// Directed bench for flags_stack (WIDTH=4, DEPTH=4). The driver issues one
// request per cycle and queues the hand-computed expected outputs, tagged with
// the cycle at which they become visible; a monitor on the falling edge pops
// and compares them. Asynchronous reset is checked directly between edges.
// ----------------------------------------------------------------------------
module tb_flags_stack;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags;
  logic       fwe;
  logic [3:0] mask;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic [3:0] flags_out;
  logic [2:0] sp;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;

  flags_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .FLAGS     (flags),
    .FWE       (fwe),
    .MASK      (mask),
    .PUSH      (push),
    .POP       (pop),
    .CLR_ERR   (clr_err),
    .FLAGS_OUT (flags_out),
    .SP        (sp),
    .FULL      (full),
    .EMPTY     (empty),
    .OVF_ERR   (ovf_err),
    .UNF_ERR   (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Scoreboard: parallel queues of name, expected packed outputs, due cycle.
  string       name_q [$];
  logic [10:0] exp_q  [$];
  int          due_q  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Packed observation: {FLAGS_OUT, SP, FULL, EMPTY, OVF_ERR, UNF_ERR}
  function automatic logic [10:0] pack_exp(input logic [3:0] f, input int s,
                                           input logic o, input logic u);
    logic [2:0] s3;
    s3 = 3'(s);
    return {f, s3, (s == 4), (s == 0), o, u};
  endfunction

  function automatic logic [10:0] observe();
    return {flags_out, sp, full, empty, ovf_err, unf_err};
  endfunction

  task automatic check(input string name, input logic [10:0] got,
                       input logic [10:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got flags=%b sp=%0d full=%b empty=%b ovf=%b unf=%b, expected flags=%b sp=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, got[10:7], got[6:4], got[3], got[2], got[1], got[0],
                  exp[10:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  // Monitor: compare every expectation that has become due.
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      check(name_q.pop_front(), observe(), exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // One request cycle: drive at the falling edge, expect after the next rise.
  task automatic step(input string name, input logic w, input logic [3:0] f,
                      input logic [3:0] m, input logic pu, input logic po,
                      input logic clr, input logic [3:0] ef, input int es,
                      input logic eo, input logic eu);
    @(negedge clk);
    fwe = w; flags = f; mask = m; push = pu; pop = po; clr_err = clr;
    name_q.push_back(name);
    exp_q.push_back(pack_exp(ef, es, eo, eu));
    due_q.push_back(cyc + 1);
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    fwe = 0; flags = 0; mask = 0; push = 0; pop = 0; clr_err = 0;
  endtask

  // Let the monitor consume everything queued so far, bounded.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    while (due_q.size() > 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (due_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never compared, required 0", due_q.size());
      name_q.delete(); exp_q.delete(); due_q.delete();
    end
  endtask

  // Drop reset between edges and check outputs before the next edge.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check(name, observe(), pack_exp(4'b0000, 0, 1'b0, 1'b0));
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    idle_inputs();

    // 1. Reset and masked writes
    async_reset("rst_async");
    step("wr_mask0101",   1, 4'b1111, 4'b0101, 0, 0, 0, 4'b0101, 0, 0, 0);
    step("fwe0_hold",     0, 4'b1010, 4'b1111, 0, 0, 0, 4'b0101, 0, 0, 0);
    step("mask0_hold",    1, 4'b1010, 4'b0000, 0, 0, 0, 4'b0101, 0, 0, 0);
    step("wr_partial",    1, 4'b1010, 4'b1100, 0, 0, 0, 4'b1001, 0, 0, 0);

    // 2. Push with simultaneous write, then pop
    step("wr_1010",       1, 4'b1010, 4'b1111, 0, 0, 0, 4'b1010, 0, 0, 0);
    step("push_wr",       1, 4'b0001, 4'b1111, 1, 0, 0, 4'b0001, 1, 0, 0);
    step("pop_old",       0, 4'b0000, 4'b0000, 0, 1, 0, 4'b1010, 0, 0, 0);

    // 3. Fill and overflow, then LIFO pops
    step("wr_1",          1, 4'd1, 4'b1111, 0, 0, 0, 4'd1, 0, 0, 0);
    step("push_1",        0, 4'd0, 4'b0000, 1, 0, 0, 4'd1, 1, 0, 0);
    step("wr_2",          1, 4'd2, 4'b1111, 0, 0, 0, 4'd2, 1, 0, 0);
    step("push_2",        0, 4'd0, 4'b0000, 1, 0, 0, 4'd2, 2, 0, 0);
    step("wr_3",          1, 4'd3, 4'b1111, 0, 0, 0, 4'd3, 2, 0, 0);
    step("push_3",        0, 4'd0, 4'b0000, 1, 0, 0, 4'd3, 3, 0, 0);
    step("wr_4",          1, 4'd4, 4'b1111, 0, 0, 0, 4'd4, 3, 0, 0);
    step("push_4_full",   0, 4'd0, 4'b0000, 1, 0, 0, 4'd4, 4, 0, 0);
    step("push_ovf",      1, 4'd7, 4'b1111, 1, 0, 0, 4'd7, 4, 1, 0);
    step("pop_4",         0, 4'd0, 4'b0000, 0, 1, 0, 4'd4, 3, 1, 0);
    step("pop_3",         0, 4'd0, 4'b0000, 0, 1, 0, 4'd3, 2, 1, 0);
    step("pop_2",         0, 4'd0, 4'b0000, 0, 1, 0, 4'd2, 1, 1, 0);
    step("pop_1",         0, 4'd0, 4'b0000, 0, 1, 0, 4'd1, 0, 1, 0);
    step("clr_ovf",       0, 4'd0, 4'b0000, 0, 0, 1, 4'd1, 0, 0, 0);

    // 4. Underflow and error clearing
    step("pop_unf",       0, 4'd0, 4'b0000, 0, 1, 0, 4'd1, 0, 0, 1);
    step("clr_vs_unf",    0, 4'd0, 4'b0000, 0, 1, 1, 4'd1, 0, 0, 1);
    step("clr_unf",       0, 4'd0, 4'b0000, 0, 0, 1, 4'd1, 0, 0, 0);

    // 5. Priority and conflict
    step("wr_6",          1, 4'b0110, 4'b1111, 0, 0, 0, 4'b0110, 0, 0, 0);
    step("push_6",        0, 4'd0,    4'b0000, 1, 0, 0, 4'b0110, 1, 0, 0);
    step("wr_9",          1, 4'b1001, 4'b1111, 0, 0, 0, 4'b1001, 1, 0, 0);
    step("push_9",        0, 4'd0,    4'b0000, 1, 0, 0, 4'b1001, 2, 0, 0);
    step("wr_3b",         1, 4'b0011, 4'b1111, 0, 0, 0, 4'b0011, 2, 0, 0);
    step("pop_beats_fwe", 1, 4'b1111, 4'b1111, 0, 1, 0, 4'b1001, 1, 0, 0);
    step("push_9b",       0, 4'd0,    4'b0000, 1, 0, 0, 4'b1001, 2, 0, 0);
    step("push_pop_fwe",  1, 4'b0000, 4'b1000, 1, 1, 0, 4'b0001, 2, 0, 0);

    // 6. Reset mid-operation
    step("push_sp3",      0, 4'd0, 4'b0000, 1, 0, 0, 4'b0001, 3, 0, 0);
    step("push_sp4",      0, 4'd0, 4'b0000, 1, 0, 0, 4'b0001, 4, 0, 0);
    step("push_ovf2",     0, 4'd0, 4'b0000, 1, 0, 0, 4'b0001, 4, 1, 0);
    step("pop_sp3",       0, 4'd0, 4'b0000, 0, 1, 0, 4'b0001, 3, 1, 0);
    drain();
    async_reset("rst_mid_op");
    step("pop_after_rst", 1, 4'b0111, 4'b1111, 0, 1, 0, 4'b0111, 0, 0, 1);
    step("push_after_rst",0, 4'd0,    4'b0000, 1, 0, 0, 4'b0111, 1, 0, 1);
    step("pop_after_rst2",0, 4'd0,    4'b0000, 0, 1, 0, 4'b0111, 0, 0, 1);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
